// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types and helpers for the cache-to-memory arbiter:
//   arb_state_t   - arbiter FSM state encoding
//   req_id_t      - requester identifier (REQ_IC / REQ_DC)
//   offset_width  - byte-offset width of a cache block (log2 of block size)
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_IC = 1'b0;
    localparam req_id_t REQ_DC = 1'b1;

    function automatic int offset_width(input int block_size);
        return $clog2(block_size);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles the ICache, DCache and memory-controller sides of the arbiter.
//   master : arbiter view (drives busy/read data to caches, strobes to memory)
//   slave  : environment view (caches and memory controller)
// Ports: icRead/icAddress/icReadData/icBusy, dcRead/dcWrite/dcAddress/
//        dcWriteData/dcReadData/dcBusy, memAddress/memRead/memWrite/
//        memWriteData/memReadData/memBusy.
interface mem_arbiter_if #(
    parameter int BLOCK_SIZE = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      icRead;
    logic [ADDR_WIDTH-1:0]     icAddress;
    logic [BLOCK_SIZE*8-1:0]   icReadData;
    logic                      icBusy;

    logic                      dcRead;
    logic                      dcWrite;
    logic [ADDR_WIDTH-1:0]     dcAddress;
    logic [BLOCK_SIZE*8-1:0]   dcWriteData;
    logic [BLOCK_SIZE*8-1:0]   dcReadData;
    logic                      dcBusy;

    logic [ADDR_WIDTH-1:0]     memAddress;
    logic                      memRead;
    logic                      memWrite;
    logic [BLOCK_SIZE*8-1:0]   memWriteData;
    logic [BLOCK_SIZE*8-1:0]   memReadData;
    logic                      memBusy;

    modport master (
        input  icRead, icAddress, dcRead, dcWrite, dcAddress, dcWriteData,
               memReadData, memBusy,
        output icReadData, icBusy, dcReadData, dcBusy,
               memAddress, memRead, memWrite, memWriteData
    );

    modport slave (
        output icRead, icAddress, dcRead, dcWrite, dcAddress, dcWriteData,
               memReadData, memBusy,
        input  icReadData, icBusy, dcReadData, dcBusy,
               memAddress, memRead, memWrite, memWriteData
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// rr_arbiter2
// Combinational two-way round-robin arbiter.
//   req        in  [1:0] request vector, indexed by req_id_t
//   last_grant in        requester served most recently
//   valid      out       at least one request present
//   grant      out       winner: sole requester, or on a tie the one
//                        that was not served last
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic       valid,
    output req_id_t    grant
);

    always_comb begin
        valid = |req;
        if (req[REQ_IC] && req[REQ_DC])
            grant = ~last_grant;
        else if (req[REQ_DC])
            grant = REQ_DC;
        else
            grant = REQ_IC;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one block-wide memory port between the ICache and the DCache.
// Requests are granted one at a time, round-robin; the block read back
// (or the write completion) is routed to the granted cache.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  master modport of mem_arbiter_if (cache and memory sides)
//
// state | meaning
// IDLE  | no transaction; arbitrate, latch grant/address/data, raise strobe
// ISSUE | strobe up, waiting for memory to raise memBusy
// WAIT  | memory busy; on memBusy falling capture read data, drop strobe
// RESP  | one cycle: granted requester sees busy=0, its data valid
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BLOCK_SIZE = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    localparam int OFF_W = offset_width(BLOCK_SIZE);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

    arb_state_t            state;
    arb_state_t            state_nxt;
    req_id_t               grant_q;
    req_id_t               last_grant;
    req_id_t               arb_grant;
    logic                  arb_valid;
    logic                  issue_en;
    logic                  complete_en;
    logic                  issue_write;
    logic [ADDR_WIDTH-1:0] req_addr;

    rr_arbiter2 u_rr (
        .req        ({bus.dcRead | bus.dcWrite, bus.icRead}),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_valid)    state_nxt = ISSUE;
            ISSUE:   if (bus.memBusy)  state_nxt = WAIT;
            WAIT:    if (!bus.memBusy) state_nxt = RESP;
            RESP:                      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue_en    = (state == IDLE) && arb_valid;
        complete_en = (state == WAIT) && !bus.memBusy;
        // A DCache request with dcWrite set is always served as a write;
        // a concurrent dcRead stays pending for a later grant.
        issue_write = (arb_grant == REQ_DC) && bus.dcWrite;
        req_addr    = (arb_grant == REQ_DC) ? bus.dcAddress : bus.icAddress;
        bus.icBusy  = bus.icRead & ~((state == RESP) && (grant_q == REQ_IC));
        bus.dcBusy  = (bus.dcRead | bus.dcWrite) & ~((state == RESP) && (grant_q == REQ_DC));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q          <= REQ_IC;
            last_grant       <= REQ_IC;
            bus.memRead      <= 1'b0;
            bus.memWrite     <= 1'b0;
            bus.memAddress   <= '0;
            bus.memWriteData <= '0;
            bus.icReadData   <= '0;
            bus.dcReadData   <= '0;
        end else begin
            if (issue_en) begin
                grant_q        <= arb_grant;
                bus.memAddress <= req_addr & ~OFF_MASK;
                if (issue_write) begin
                    bus.memWrite     <= 1'b1;
                    bus.memWriteData <= bus.dcWriteData;
                end else begin
                    bus.memRead <= 1'b1;
                end
            end
            if (complete_en) begin
                bus.memRead  <= 1'b0;
                bus.memWrite <= 1'b0;
                last_grant   <= grant_q;
                if (bus.memRead) begin
                    if (grant_q == REQ_DC)
                        bus.dcReadData <= bus.memReadData;
                    else
                        bus.icReadData <= bus.memReadData;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int BS = 32;
    localparam int AW = 32;
    localparam int DW = BS * 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // reference model state
    logic [DW-1:0] exp_ic;
    logic [DW-1:0] exp_dc;
    bit            model_last;   // 0 = ICache served last, 1 = DCache

    mem_arbiter_if #(.BLOCK_SIZE(BS), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.BLOCK_SIZE(BS), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a - (a % BS);
    endfunction

    // Round robin at the level of the rule: a lone requester wins; on a tie
    // the requester not served last wins. Returns 1 for DCache.
    function automatic bit model_pick(input bit ic, input bit dc, input bit last);
        if (ic && dc) return !last;
        return dc;
    endfunction

    function automatic logic [DW-1:0] rand_blk();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic clear_inputs();
        bus.icRead = 0; bus.icAddress = '0;
        bus.dcRead = 0; bus.dcWrite = 0; bus.dcAddress = '0; bus.dcWriteData = '0;
        bus.memReadData = '0; bus.memBusy = 0;
    endtask

    // Memory side: called on the negedge where the strobe is first seen;
    // returns on the negedge of the RESP cycle.
    task automatic serve(input int busy_cycles, input logic [DW-1:0] data);
        bus.memBusy = 1;
        repeat (busy_cycles) @(negedge clk);
        bus.memReadData = data;
        bus.memBusy = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        exp_ic = '0; exp_dc = '0; model_last = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        @(negedge clk);
        #2 rst = 0;
        #1;
        n_checks++;
        if (bus.memRead !== 1'b0 || bus.memWrite !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: got rd=%b wr=%b, want 0 0", bus.memRead, bus.memWrite);
        end
        n_checks++;
        if (bus.memAddress !== '0) begin
            n_fail++; $display("FAIL reset_addr: got %h, want 0", bus.memAddress);
        end
        n_checks++;
        if (bus.memWriteData !== '0 || bus.icReadData !== '0 || bus.dcReadData !== '0) begin
            n_fail++; $display("FAIL reset_data: got wd=%h ic=%h dc=%h, want 0", bus.memWriteData, bus.icReadData, bus.dcReadData);
        end
        n_checks++;
        if (bus.icBusy !== 1'b0 || bus.dcBusy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got ic=%b dc=%b, want 0 0", bus.icBusy, bus.dcBusy);
        end
        @(negedge clk);
        rst = 1;
        exp_ic = '0; exp_dc = '0; model_last = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.memRead !== 1'b0 || bus.memWrite !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_strobe: got rd=%b wr=%b, want 0 0", bus.memRead, bus.memWrite);
        end
    endtask

    task automatic test_icache_alone();
        logic [DW-1:0] blk;
        blk = 256'h12345678_9ABCDEF1_23456789_ABCDEF12_3456789A_BCDEF123_456789AB_CDEF1234;
        bus.icAddress = 32'hF0F0F090;
        bus.icRead = 1;
        #1;
        n_checks++;
        if (bus.icBusy !== 1'b1) begin
            n_fail++; $display("FAIL ic_busy_pending: got %b, want 1", bus.icBusy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.memRead !== 1'b1 || bus.memWrite !== 1'b0) begin
            n_fail++; $display("FAIL ic_strobe: got rd=%b wr=%b, want 1 0", bus.memRead, bus.memWrite);
        end
        n_checks++;
        if (bus.memAddress !== 32'hF0F0F080) begin
            n_fail++; $display("FAIL ic_addr: got %h, want f0f0f080", bus.memAddress);
        end
        serve(3, blk);
        n_checks++;
        if (bus.icReadData !== blk || bus.icBusy !== 1'b0) begin
            n_fail++; $display("FAIL ic_resp: got data=%h busy=%b, want %h 0", bus.icReadData, bus.icBusy, blk);
        end
        n_checks++;
        if (bus.dcReadData !== exp_dc) begin
            n_fail++; $display("FAIL ic_dc_untouched: got %h, want %h", bus.dcReadData, exp_dc);
        end
        exp_ic = blk; model_last = 0;
        bus.icRead = 0;
        @(negedge clk);
        n_checks++;
        if (bus.memRead !== 1'b0 || bus.icBusy !== 1'b0) begin
            n_fail++; $display("FAIL ic_after: got rd=%b busy=%b, want 0 0", bus.memRead, bus.icBusy);
        end
    endtask

    // Both caches keep re-requesting; grants must alternate, starting with
    // DCache after reset, with a single IDLE cycle between grants.
    task automatic test_round_robin();
        bit g;
        logic [DW-1:0] d;
        do_reset();
        bus.icAddress = $urandom; bus.dcAddress = $urandom;
        bus.icRead = 1; bus.dcRead = 1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            g = model_pick(bus.icRead, bus.dcRead, model_last);
            if (k == 0) begin
                n_checks++;
                if (g !== 1'b1) begin
                    n_fail++; $display("FAIL rr_model_first: got %0d, want DC(1)", g);
                end
            end
            n_checks++;
            if (bus.memRead !== 1'b1 || bus.memAddress !== align(g ? bus.dcAddress : bus.icAddress)) begin
                n_fail++; $display("FAIL rr_issue%0d: got rd=%b addr=%h, want 1 %h", k, bus.memRead, bus.memAddress, align(g ? bus.dcAddress : bus.icAddress));
            end
            d = rand_blk();
            serve(1 + int'($urandom % 3), d);
            if (g) exp_dc = d; else exp_ic = d;
            model_last = g;
            n_checks++;
            if (bus.icBusy !== g || bus.dcBusy !== !g) begin
                n_fail++; $display("FAIL rr_busy%0d: got ic=%b dc=%b, want %b %b", k, bus.icBusy, bus.dcBusy, g, !g);
            end
            n_checks++;
            if (bus.icReadData !== exp_ic || bus.dcReadData !== exp_dc) begin
                n_fail++; $display("FAIL rr_data%0d: got ic=%h dc=%h, want %h %h", k, bus.icReadData, bus.dcReadData, exp_ic, exp_dc);
            end
            if (k == 3) begin
                bus.icRead = 0; bus.dcRead = 0;
                @(negedge clk);
                break;
            end
            if (g) bus.dcAddress = $urandom; else bus.icAddress = $urandom;
            @(negedge clk);
            n_checks++;
            if (bus.memRead !== 1'b0) begin
                n_fail++; $display("FAIL rr_idle_gap%0d: got rd=%b, want 0", k, bus.memRead);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_dc_write();
        logic [DW-1:0] wd;
        wd = {32{8'hAB}};
        bus.dcAddress = 32'h0000_1234; bus.dcWriteData = wd; bus.dcWrite = 1;
        @(negedge clk);
        n_checks++;
        if (bus.memWrite !== 1'b1 || bus.memRead !== 1'b0) begin
            n_fail++; $display("FAIL dcw_strobe: got wr=%b rd=%b, want 1 0", bus.memWrite, bus.memRead);
        end
        n_checks++;
        if (bus.memAddress !== 32'h0000_1220 || bus.memWriteData !== wd) begin
            n_fail++; $display("FAIL dcw_addr_data: got %h %h, want 00001220 %h", bus.memAddress, bus.memWriteData, wd);
        end
        serve(2, rand_blk());
        model_last = 1;
        n_checks++;
        if (bus.dcBusy !== 1'b0 || bus.dcReadData !== exp_dc || bus.icReadData !== exp_ic) begin
            n_fail++; $display("FAIL dcw_resp: got busy=%b dc=%h ic=%h, want 0 %h %h", bus.dcBusy, bus.dcReadData, bus.icReadData, exp_dc, exp_ic);
        end
        bus.dcWrite = 0;
        @(negedge clk);
        n_checks++;
        if (bus.memWrite !== 1'b0) begin
            n_fail++; $display("FAIL dcw_after: got wr=%b, want 0", bus.memWrite);
        end
    endtask

    task automatic test_both_rw();
        logic [DW-1:0] d;
        bus.dcAddress = $urandom; bus.dcWriteData = rand_blk();
        bus.dcRead = 1; bus.dcWrite = 1;
        @(negedge clk);
        n_checks++;
        if (bus.memWrite !== 1'b1 || bus.memRead !== 1'b0 || bus.memWriteData !== bus.dcWriteData) begin
            n_fail++; $display("FAIL rw_write_first: got wr=%b rd=%b, want 1 0", bus.memWrite, bus.memRead);
        end
        serve(1, rand_blk());
        model_last = 1;
        n_checks++;
        if (bus.dcReadData !== exp_dc) begin
            n_fail++; $display("FAIL rw_dc_kept: got %h, want %h", bus.dcReadData, exp_dc);
        end
        bus.dcWrite = 0;
        @(negedge clk);
        n_checks++;
        if (bus.dcBusy !== 1'b1 || bus.memRead !== 1'b0) begin
            n_fail++; $display("FAIL rw_gap: got busy=%b rd=%b, want 1 0", bus.dcBusy, bus.memRead);
        end
        @(negedge clk);
        n_checks++;
        if (bus.memRead !== 1'b1 || bus.memWrite !== 1'b0 || bus.memAddress !== align(bus.dcAddress)) begin
            n_fail++; $display("FAIL rw_read: got rd=%b wr=%b addr=%h, want 1 0 %h", bus.memRead, bus.memWrite, bus.memAddress, align(bus.dcAddress));
        end
        d = rand_blk();
        serve(2, d);
        exp_dc = d;
        n_checks++;
        if (bus.dcReadData !== exp_dc) begin
            n_fail++; $display("FAIL rw_read_data: got %h, want %h", bus.dcReadData, exp_dc);
        end
        bus.dcRead = 0;
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        logic [DW-1:0] d;
        int strobes;
        d = rand_blk();
        bus.icAddress = $urandom; bus.icRead = 1;
        @(negedge clk);
        bus.memBusy = 1;
        @(negedge clk);
        bus.icRead = 0;
        @(negedge clk);
        n_checks++;
        if (bus.memRead !== 1'b1 || bus.icBusy !== 1'b0) begin
            n_fail++; $display("FAIL wd_hold: got rd=%b busy=%b, want 1 0", bus.memRead, bus.icBusy);
        end
        bus.memReadData = d; bus.memBusy = 0;
        @(negedge clk);
        exp_ic = d; model_last = 0;
        n_checks++;
        if (bus.icReadData !== exp_ic || bus.memRead !== 1'b0) begin
            n_fail++; $display("FAIL wd_data: got %h rd=%b, want %h 0", bus.icReadData, bus.memRead, exp_ic);
        end
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.memRead || bus.memWrite) strobes++;
        end
        n_checks++;
        if (strobes != 0) begin
            n_fail++; $display("FAIL wd_no_reissue: got %0d strobe cycles, want 0", strobes);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        bus.icAddress = $urandom; bus.icRead = 1;
        @(negedge clk);
        bus.memBusy = 1;
        @(negedge clk);
        #2 rst = 0;
        #1;
        n_checks++;
        if (bus.memRead !== 1'b0 || bus.memAddress !== '0) begin
            n_fail++; $display("FAIL rstmid_strobe: got rd=%b addr=%h, want 0 0", bus.memRead, bus.memAddress);
        end
        n_checks++;
        if (bus.icReadData !== '0 || bus.dcReadData !== '0 || bus.memWriteData !== '0) begin
            n_fail++; $display("FAIL rstmid_data: got ic=%h dc=%h wd=%h, want 0", bus.icReadData, bus.dcReadData, bus.memWriteData);
        end
        exp_ic = '0; exp_dc = '0; model_last = 0;
        @(negedge clk);
        bus.memBusy = 0;
        rst = 1;
        @(negedge clk);
        n_checks++;
        if (bus.memRead !== 1'b1 || bus.memAddress !== align(bus.icAddress)) begin
            n_fail++; $display("FAIL rstmid_reissue: got rd=%b addr=%h, want 1 %h", bus.memRead, bus.memAddress, align(bus.icAddress));
        end
        d = rand_blk();
        serve(1, d);
        exp_ic = d;
        n_checks++;
        if (bus.icReadData !== exp_ic) begin
            n_fail++; $display("FAIL rstmid_data_after: got %h, want %h", bus.icReadData, exp_ic);
        end
        bus.icRead = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit p_ic, p_rd, p_wr, g, wr;
        logic [DW-1:0] d;
        p_ic = 0; p_rd = 0; p_wr = 0;
        for (int r = 0; r < 40; r++) begin
            if (!p_ic && $urandom_range(0, 1) == 1) begin
                p_ic = 1; bus.icAddress = $urandom;
            end
            if (!p_rd && !p_wr && $urandom_range(0, 1) == 1) begin
                p_rd = $urandom_range(0, 1) == 1;
                p_wr = !p_rd || ($urandom_range(0, 1) == 1);
                bus.dcAddress = $urandom; bus.dcWriteData = rand_blk();
            end
            if (!p_ic && !p_rd && !p_wr) begin
                p_ic = 1; bus.icAddress = $urandom;
            end
            bus.icRead = p_ic; bus.dcRead = p_rd; bus.dcWrite = p_wr;
            g  = model_pick(p_ic, p_rd | p_wr, model_last);
            wr = g && p_wr;
            @(negedge clk);
            n_checks++;
            if (bus.memRead !== !wr || bus.memWrite !== wr ||
                bus.memAddress !== align(g ? bus.dcAddress : bus.icAddress) ||
                (wr && bus.memWriteData !== bus.dcWriteData)) begin
                n_fail++; $display("FAIL rand_issue%0d: got rd=%b wr=%b addr=%h, want %b %b %h", r, bus.memRead, bus.memWrite, bus.memAddress, !wr, wr, align(g ? bus.dcAddress : bus.icAddress));
            end
            d = rand_blk();
            serve(1 + int'($urandom % 3), d);
            model_last = g;
            if (!g) begin exp_ic = d; end
            else if (!wr) begin exp_dc = d; end
            n_checks++;
            if (bus.icBusy !== (p_ic && g) || bus.dcBusy !== ((p_rd || p_wr) && !g)) begin
                n_fail++; $display("FAIL rand_busy%0d: got ic=%b dc=%b, want %b %b", r, bus.icBusy, bus.dcBusy, p_ic && g, (p_rd || p_wr) && !g);
            end
            n_checks++;
            if (bus.icReadData !== exp_ic || bus.dcReadData !== exp_dc) begin
                n_fail++; $display("FAIL rand_data%0d: got ic=%h dc=%h, want %h %h", r, bus.icReadData, bus.dcReadData, exp_ic, exp_dc);
            end
            if (!g) p_ic = 0;
            else if (wr) p_wr = 0;
            else p_rd = 0;
            bus.icRead = p_ic; bus.dcRead = p_rd; bus.dcWrite = p_wr;
            @(negedge clk);
        end
        bus.icRead = 0; bus.dcRead = 0; bus.dcWrite = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1;
        clear_inputs();
        test_reset();
        test_icache_alone();
        test_round_robin();
        test_dc_write();
        test_both_rw();
        test_withdraw();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
